// File: rtl/pipelined_subtractor16.sv
`default_nettype none
// ============================================================================
// pipelined_subtractor16 : two-stage a - b - bIn, low half then high half,
//                          valid/ready on both sides.  Rev 1.0
// ============================================================================
module pipelined_subtractor16 #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rstN,
  input  logic             inValid,
  output logic             inReady,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bIn,
  output logic             outValid,
  input  logic             outReady,
  output logic [WIDTH-1:0] diff,
  output logic             bOut,
  output logic             overflow
);

  localparam int HALF = WIDTH / 2;

  logic            s1ValidQ, s1ValidD;
  logic [HALF-1:0] s1DiffLoQ, s1DiffLoD;
  logic            s1BorrowQ, s1BorrowD;
  logic [HALF-1:0] s1AHiQ, s1AHiD;
  logic [HALF-1:0] s1BHiQ, s1BHiD;

  logic             s2ValidQ, s2ValidD;
  logic [WIDTH-1:0] diffQ, diffD;
  logic             bOutQ, bOutD;
  logic             ovfQ, ovfD;

  logic          s2Adv;
  logic          inXfer;
  logic [HALF:0] loSum;
  logic [HALF:0] hiSum;

  assign s2Adv   = !s2ValidQ || outReady;
  assign inReady = !s1ValidQ || s2Adv;
  assign inXfer  = inValid && inReady;

  // Subtraction as a + ~b + carry, carry-in of the low half is ~bIn
  assign loSum = {1'b0, a[HALF-1:0]} + {1'b0, ~b[HALF-1:0]} + {{HALF{1'b0}}, ~bIn};
  assign hiSum = {1'b0, s1AHiQ} + {1'b0, ~s1BHiQ} + {{HALF{1'b0}}, ~s1BorrowQ};

  always_comb begin
    s1ValidD  = s1ValidQ;
    s1DiffLoD = s1DiffLoQ;
    s1BorrowD = s1BorrowQ;
    s1AHiD    = s1AHiQ;
    s1BHiD    = s1BHiQ;
    if (inXfer) begin
      s1ValidD  = 1'b1;
      s1DiffLoD = loSum[HALF-1:0];
      s1BorrowD = ~loSum[HALF];
      s1AHiD    = a[WIDTH-1:HALF];
      s1BHiD    = b[WIDTH-1:HALF];
    end else if (s2Adv) begin
      s1ValidD = 1'b0;
    end

    s2ValidD = s2ValidQ;
    diffD    = diffQ;
    bOutD    = bOutQ;
    ovfD     = ovfQ;
    if (s2Adv) begin
      s2ValidD = s1ValidQ;
      if (s1ValidQ) begin
        diffD = {hiSum[HALF-1:0], s1DiffLoQ};
        bOutD = ~hiSum[HALF];
        // Sign bits of the operands are the MSBs of the stored high halves
        ovfD  = (s1AHiQ[HALF-1] != s1BHiQ[HALF-1]) &&
                (hiSum[HALF-1] != s1AHiQ[HALF-1]);
      end
    end
  end

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      s1ValidQ  <= 1'b0;
      s1DiffLoQ <= '0;
      s1BorrowQ <= 1'b0;
      s1AHiQ    <= '0;
      s1BHiQ    <= '0;
      s2ValidQ  <= 1'b0;
      diffQ     <= '0;
      bOutQ     <= 1'b0;
      ovfQ      <= 1'b0;
    end else begin
      s1ValidQ  <= s1ValidD;
      s1DiffLoQ <= s1DiffLoD;
      s1BorrowQ <= s1BorrowD;
      s1AHiQ    <= s1AHiD;
      s1BHiQ    <= s1BHiD;
      s2ValidQ  <= s2ValidD;
      diffQ     <= diffD;
      bOutQ     <= bOutD;
      ovfQ      <= ovfD;
    end
  end

  assign outValid = s2ValidQ;
  assign diff     = diffQ;
  assign bOut     = bOutQ;
  assign overflow = ovfQ;

endmodule
`default_nettype wire

// File: doc/pipelined_subtractor16.md
Name: pipelined_subtractor16

Overview:
- Two-stage pipelined subtractor. Computes diff = a - b - bIn with borrow-out and signed overflow.
- Inverse-direction companion to the team's ripple-carry 16-bit adder. Splits the operation at the byte boundary: low half in stage 1, high half in stage 2.
- Valid/ready handshakes on both sides, so it drops into the same datapath pipelines as the adder with backpressure support.

Parameters:
- WIDTH, 16, operand width. Must be even and at least 2. Split point is WIDTH/2.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rstN  input  1  asynchronous, active-low reset.
- inValid  input  1  operand set presented.
- inReady  output  1  block accepts operands this cycle.
- a  input  WIDTH  minuend.
- b  input  WIDTH  subtrahend.
- bIn  input  1  borrow-in.
- outValid  output  1  result presented.
- outReady  input  1  consumer accepts result this cycle.
- diff  output  WIDTH  (a - b - bIn) mod 2^WIDTH.
- bOut  output  1  borrow-out; 1 iff unsigned a < b + bIn.
- overflow  output  1  signed two's-complement overflow.

Behaviour:
- Reset (rstN low, asynchronous):
  - outValid=0, diff=0, bOut=0, overflow=0, both stage valids=0, all pipeline registers=0.
  - inReady is combinational and reads 1 during and after reset.
  - Reset mid-operation discards all in-flight operands. No stale result may appear after release.
- Arithmetic: subtraction = a + ~b + carry-in, with carry-in = ~bIn.
  - Stage 1: low half. Produces diffLo[WIDTH/2-1:0] and the internal low borrow. Registers diffLo, the borrow, aHi, bHi, and sign bits a[WIDTH-1], b[WIDTH-1].
  - Stage 2: high half, using the registered borrow as its borrow-in.
  - bOut = NOT(final carry).
  - overflow = (a[MSB] != b[MSB]) AND (diff[MSB] != a[MSB]).
  - bIn is included in the subtraction but not in the overflow term.
- Handshake:
  - Input transfer when inValid && inReady. Output transfer when outValid && outReady.
  - s2Adv = !s2Valid || outReady. Stage 2 loads from stage 1 when s2Adv.
  - inReady = !s1Valid || s2Adv. Combinational; no dependency on inValid.
  - On an input transfer, stage 1 loads and s1Valid=1. Otherwise, if s2Adv, s1Valid=0.
  - On s2Adv, s2Valid takes s1Valid.
  - outValid = s2Valid. diff, bOut and overflow are registered stage-2 outputs.
- Latency and throughput:
  - Latency: an input accepted at edge N gives outValid=1 after edge N+1 if not stalled.
  - Throughput: one result per cycle with outReady held high.
- Stall:
  - While outValid && !outReady, diff/bOut/overflow stay stable and stage 2 holds.
  - Stage 1 may still fill. With both stages full and outReady=0, inReady=0.
- Simultaneous input accept and output accept with a full pipeline: both occur in the same cycle, with no bubble.
- Ordering: results leave strictly in acceptance order. No drop, no duplicate.
- Width wrap: diff wraps modulo 2^WIDTH. bOut flags the wrap.

Test Plan:
- a=0x1234, b=0x0234, bIn=0 accepted with outReady=1 -> after 2 edges: outValid=1, diff=0x1000, bOut=0, overflow=0.
- Low-to-high borrow propagation: a=0x0100, b=0x0001 -> diff=0x00FF, bOut=0.
- Unsigned underflow: a=0x0000, b=0x0001 -> diff=0xFFFF, bOut=1, overflow=0.
- Borrow-in case: a=0x0005, b=0x0005, bIn=1 -> diff=0xFFFF, bOut=1.
- Signed overflow: a=0x8000, b=0x0001 -> diff=0x7FFF, bOut=0, overflow=1.
- Streaming and backpressure: 5 back-to-back operands with outReady=1 -> 5 in-order results on consecutive cycles. Then outReady=0 for 3 cycles during a stream:
  - inReady=0 once 2 entries are held.
  - diff stays stable throughout the stall.
  - After release, the remaining results drain in order with no loss.
- Reset: drive rstN low while 2 ops are in flight -> outValid=0 immediately (asynchronous), inReady=1. After release with no new input, outValid stays 0.
